// File: rtl/spn_iter_core.sv
// Iterative SPN block cipher engine. It computes one round per clock and uses a
// valid/ready handshake with back-pressure on both the request and result sides.
package spn_sbox_pkg;
    localparam logic [15:0][3:0] SBOX     = 64'h7095_C6A3_8BF2_1D4E;
    localparam logic [15:0][3:0] SBOX_INV = 64'h502B_69D7_FAC1_843E;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        return SBOX[n];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] n);
        return SBOX_INV[n];
    endfunction
endpackage

// state  | meaning
// IDLE   | waiting for a request; round 0 is computed on the accepting edge
// RUN    | applying rounds 1..ROUNDS-1, one per clock
// DONE   | result held on data_out/status until out_ready
module spn_iter_core #(
    parameter int BLOCK_W = 16,
    parameter int KEY_W   = 32,
    parameter int ROUNDS  = 3,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         opcode,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   key_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic [1:0]         status,
    output logic               busy
);
    import spn_sbox_pkg::*;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;
    localparam int IDX_W = $clog2(BLOCK_W);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] RK_OUT = CNT_W'(ROUNDS);

    function automatic logic [BLOCK_W-1:0] round_key(input logic [KEY_W-1:0] k,
                                                     input logic [CNT_W-1:0] r);
        logic [KEY_W-1:0] rot;
        rot = k;
        for (int i = 0; i < ROUNDS; i++)
            if (CNT_W'(i) < r) rot = {rot[KEY_W-5:0], rot[KEY_W-1:KEY_W-4]};
        return rot[KEY_W-1 -: BLOCK_W];
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_layer(input logic [BLOCK_W-1:0] x, input logic inv);
        logic [BLOCK_W-1:0] y;
        y = x;
        for (int i = 0; i < BLOCK_W/4; i++)
            y[IDX_W'(4*i) +: 4] = inv ? sbox_inv(x[IDX_W'(4*i) +: 4]) : sbox(x[IDX_W'(4*i) +: 4]);
        return y;
    endfunction

    // The MSB is a fixed point of both P and P^-1, so it keeps its copy from x.
    function automatic logic [BLOCK_W-1:0] perm(input logic [BLOCK_W-1:0] x, input logic inv);
        logic [BLOCK_W-1:0] y;
        y = x;
        for (int p = 0; p < BLOCK_W-1; p++) begin
            if (inv) y[IDX_W'(((BLOCK_W/4)*p) % (BLOCK_W-1))] = x[IDX_W'(p)];
            else     y[IDX_W'((4*p) % (BLOCK_W-1))]           = x[IDX_W'(p)];
        end
        return y;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] x_q, x_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               dec_q, dec_d;
    logic [BLOCK_W-1:0] data_out_q, data_out_d;
    logic [1:0]         status_q, status_d;

    logic               idle, rnd_dec, rnd_last;
    logic [CNT_W-1:0]   step, rnd_idx;
    logic [KEY_W-1:0]   rnd_key;
    logic [BLOCK_W-1:0] rnd_in, rnd_out;

    // A single round datapath. In IDLE it is fed straight from the request
    // ports, so that the accepting edge already performs round 0.
    always_comb begin
        idle     = (state_q == S_IDLE);
        rnd_dec  = idle ? (opcode == OP_DEC) : dec_q;
        rnd_key  = idle ? key_in : key_q;
        step     = idle ? '0 : cnt_q;
        rnd_last = (step == LAST);
        rnd_in   = idle ? data_in : x_q;
        rnd_idx  = '0;
        rnd_out  = '0;
        if (rnd_dec) begin
            rnd_idx = LAST - step;
            if (idle) rnd_in = rnd_in ^ round_key(rnd_key, RK_OUT);
            rnd_out = (step != '0) ? perm(rnd_in, 1'b1) : rnd_in;
            rnd_out = sub_layer(rnd_out, 1'b1) ^ round_key(rnd_key, rnd_idx);
        end else begin
            rnd_idx = step;
            rnd_out = sub_layer(rnd_in ^ round_key(rnd_key, rnd_idx), 1'b0);
            rnd_out = rnd_last ? (rnd_out ^ round_key(rnd_key, RK_OUT)) : perm(rnd_out, 1'b0);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        key_d      = key_q;
        dec_d      = dec_q;
        data_out_d = data_out_q;
        status_d   = status_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (opcode == OP_ENC || opcode == OP_DEC) begin
                        key_d = key_in;
                        dec_d = (opcode == OP_DEC);
                        x_d   = rnd_out;
                        if (rnd_last) begin
                            state_d    = S_DONE;
                            data_out_d = rnd_out;
                            status_d   = opcode;
                            cnt_d      = '0;
                        end else begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(1);
                        end
                    end else if (opcode == OP_BAD) begin
                        state_d    = S_DONE;
                        data_out_d = '0;
                        status_d   = OP_BAD;
                    end
                end
            end
            S_RUN: begin
                x_d   = rnd_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (rnd_last) begin
                    state_d    = S_DONE;
                    data_out_d = rnd_out;
                    status_d   = dec_q ? OP_DEC : OP_ENC;
                    cnt_d      = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    data_out_d = '0;
                    status_d   = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                data_out_d = '0;
                status_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            key_q      <= '0;
            dec_q      <= 1'b0;
            data_out_q <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            key_q      <= key_d;
            dec_q      <= dec_d;
            data_out_q <= data_out_d;
            status_q   <= status_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign data_out  = data_out_q;
    assign status    = status_q;
endmodule

// File: tb/tb_spn_iter_core.sv
// Testbench for spn_iter_core: a 16-bit/3-round instance and a 32-bit/8-round
// instance, each checked against a plain-arithmetic cipher model.
module tb_spn_iter_core;
    localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                                         4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv_a, rdy_a, ov_a, or_a, busy_a;
    logic [1:0]  op_a, st_a;
    logic [15:0] din_a, dout_a;
    logic [31:0] key_a;
    logic        iv_b, rdy_b, ov_b, or_b, busy_b;
    logic [1:0]  op_b, st_b;
    logic [31:0] din_b, dout_b;
    logic [63:0] key_b;

    spn_iter_core #(.BLOCK_W(16), .KEY_W(32), .ROUNDS(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(rdy_a), .opcode(op_a),
        .data_in(din_a), .key_in(key_a), .out_valid(ov_a), .out_ready(or_a),
        .data_out(dout_a), .status(st_a), .busy(busy_a));

    spn_iter_core #(.BLOCK_W(32), .KEY_W(64), .ROUNDS(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(rdy_b), .opcode(op_b),
        .data_in(din_b), .key_in(key_b), .out_valid(ov_b), .out_ready(or_b),
        .data_out(dout_b), .status(st_b), .busy(busy_b));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(input int n);
        return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] m_rk(input logic [63:0] k, input int kw, input int bw, input int r);
        int s;
        logic [63:0] rot;
        s = (4 * r) % kw;
        rot = (s == 0) ? k : (((k << s) | (k >> (kw - s))) & msk(kw));
        return (rot >> (kw - bw)) & msk(bw);
    endfunction

    function automatic logic [63:0] m_sub(input logic [63:0] x, input int bw, input bit inv);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < bw / 4; i++) begin
            logic [3:0] n, o;
            n = x[4*i +: 4];
            o = 4'd0;
            if (!inv) o = SBOX[n];
            else for (int j = 0; j < 16; j++) if (SBOX[j] == n) o = 4'(j);
            y[4*i +: 4] = o;
        end
        return y;
    endfunction

    function automatic logic [63:0] m_perm(input logic [63:0] x, input int bw, input bit inv);
        logic [63:0] y;
        y = x;
        for (int p = 0; p < bw - 1; p++)
            y[inv ? (((bw / 4) * p) % (bw - 1)) : ((4 * p) % (bw - 1))] = x[p];
        return y;
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] x, input logic [63:0] k,
                                          input int bw, input int kw, input int nr);
        for (int r = 0; r < nr; r++) begin
            x = m_sub(x ^ m_rk(k, kw, bw, r), bw, 1'b0);
            if (r < nr - 1) x = m_perm(x, bw, 1'b0);
        end
        return x ^ m_rk(k, kw, bw, nr);
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] x, input logic [63:0] k,
                                          input int bw, input int kw, input int nr);
        x = x ^ m_rk(k, kw, bw, nr);
        for (int r = nr - 1; r >= 0; r--) begin
            if (r < nr - 1) x = m_perm(x, bw, 1'b1);
            x = m_sub(x, bw, 1'b1) ^ m_rk(k, kw, bw, r);
        end
        return x;
    endfunction

    function automatic logic [15:0] enc16(input logic [15:0] x, input logic [31:0] k);
        return 16'(m_enc({48'd0, x}, {32'd0, k}, 16, 32, 3));
    endfunction
    function automatic logic [15:0] dec16(input logic [15:0] x, input logic [31:0] k);
        return 16'(m_dec({48'd0, x}, {32'd0, k}, 16, 32, 3));
    endfunction
    function automatic logic [31:0] enc32(input logic [31:0] x, input logic [63:0] k);
        return 32'(m_enc({32'd0, x}, k, 32, 64, 8));
    endfunction

    // ---------------- DUT access helpers ----------------
    task automatic drive(input int d, input logic v, input logic [1:0] op,
                         input logic [31:0] data, input logic [63:0] key);
        if (d == 0) begin iv_a = v; op_a = op; din_a = data[15:0]; key_a = key[31:0]; end
        else        begin iv_b = v; op_b = op; din_b = data;       key_b = key;       end
    endtask

    task automatic set_ordy(input int d, input logic v);
        if (d == 0) or_a = v; else or_b = v;
    endtask

    task automatic sample(input int d, output logic ov, output logic rdy, output logic bsy,
                          output logic [31:0] dq, output logic [1:0] sq);
        if (d == 0) begin ov = ov_a; rdy = rdy_a; bsy = busy_a; dq = {16'd0, dout_a}; sq = st_a; end
        else        begin ov = ov_b; rdy = rdy_b; bsy = busy_b; dq = dout_b;          sq = st_b; end
    endtask

    // One request, result capture, optional back-pressure, then release.
    task automatic run_block(input int d, input logic [1:0] op, input logic [31:0] data,
                             input logic [63:0] key, input int hold,
                             output logic [31:0] res, output logic [1:0] st, output int lat);
        logic ov, rdy, bsy;
        logic [31:0] dq;
        logic [1:0] sq;
        int waitc;
        set_ordy(d, 1'b0);
        sample(d, ov, rdy, bsy, dq, sq);
        waitc = 0;
        while (!rdy && waitc < 50) begin @(posedge clk); #1; sample(d, ov, rdy, bsy, dq, sq); waitc++; end
        drive(d, 1'b1, op, data, key);
        @(posedge clk); #1;
        drive(d, 1'b0, 2'b00, $urandom, {$urandom, $urandom});
        lat = 1;
        sample(d, ov, rdy, bsy, dq, sq);
        while (!ov && lat < 40) begin @(posedge clk); #1; lat++; sample(d, ov, rdy, bsy, dq, sq); end
        check("out_valid_seen", ov, 1'b1);
        res = dq;
        st  = sq;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            sample(d, ov, rdy, bsy, dq, sq);
            check("hold_stable", {ov, rdy, sq, dq}, {1'b1, 1'b0, st, res});
        end
        set_ordy(d, 1'b1);
        @(posedge clk); #1;
        set_ordy(d, 1'b0);
        sample(d, ov, rdy, bsy, dq, sq);
        check("release", {ov, rdy, bsy, sq, dq}, {1'b0, 1'b1, 1'b0, 2'b00, 32'd0});
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [31:0] key;
        int          hold;
        logic [15:0] exp_d;
        logic [1:0]  exp_s;
        int          exp_lat;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [31:0] res, r2, x;
        logic [63:0] k, kcur;
        logic [31:0] dcur;
        logic [1:0]  st, op;
        logic [15:0] e;
        logic        prev_rdy;
        int          lat, last_acc, n_acc;
        logic [15:0] q[$];

        tbl[0] = '{op: 2'b01, data: 16'h1234, key: 32'hA5A5_3C3C, hold: 0,
                   exp_d: enc16(16'h1234, 32'hA5A5_3C3C), exp_s: 2'b01, exp_lat: 3};
        tbl[1] = '{op: 2'b10, data: enc16(16'h1234, 32'hA5A5_3C3C), key: 32'hA5A5_3C3C, hold: 0,
                   exp_d: 16'h1234, exp_s: 2'b10, exp_lat: 3};
        tbl[2] = '{op: 2'b01, data: 16'hBEEF, key: 32'h0123_4567, hold: 10,
                   exp_d: enc16(16'hBEEF, 32'h0123_4567), exp_s: 2'b01, exp_lat: 3};
        tbl[3] = '{op: 2'b11, data: 16'h5555, key: 32'hDEAD_BEEF, hold: 3,
                   exp_d: 16'h0000, exp_s: 2'b11, exp_lat: 1};
        tbl[4] = '{op: 2'b01, data: 16'h0000, key: 32'h0000_0000, hold: 0,
                   exp_d: enc16(16'h0000, 32'h0), exp_s: 2'b01, exp_lat: 3};
        tbl[5] = '{op: 2'b10, data: 16'hFFFF, key: 32'hFFFF_FFFF, hold: 2,
                   exp_d: dec16(16'hFFFF, 32'hFFFF_FFFF), exp_s: 2'b10, exp_lat: 3};

        rst_n = 1'b0;
        drive(0, 1'b0, 2'b00, 32'd0, 64'd0);
        drive(1, 1'b0, 2'b00, 32'd0, 64'd0);
        or_a = 1'b0;
        or_b = 1'b0;
        #2;
        check("reset_a", {ov_a, rdy_a, busy_a, st_a, dout_a}, {1'b0, 1'b1, 1'b0, 2'b00, 16'h0});
        check("reset_b", {ov_b, rdy_b, busy_b, st_b, dout_b}, {1'b0, 1'b1, 1'b0, 2'b00, 32'h0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_block(0, tbl[i].op, {16'd0, tbl[i].data}, {32'd0, tbl[i].key}, tbl[i].hold, res, st, lat);
            check("tbl_result", {st, res}, {tbl[i].exp_s, 16'd0, tbl[i].exp_d});
            check("tbl_latency", lat, tbl[i].exp_lat);
        end

        // nop is consumed silently
        drive(0, 1'b1, 2'b00, 32'h1234, 64'h5678);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b00, 32'd0, 64'd0);
        for (int c = 0; c < 20; c++) begin
            check("nop_quiet", {ov_a, rdy_a, busy_a}, {1'b0, 1'b1, 1'b0});
            @(posedge clk); #1;
        end

        // reset in the middle of RUN
        drive(0, 1'b1, 2'b01, 32'h00C3, 64'h1111_2222);
        @(posedge clk); #1;
        drive(0, 1'b0, 2'b00, 32'd0, 64'd0);
        @(posedge clk); #1;
        check("in_run_before_reset", {busy_a, ov_a}, {1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("async_reset", {ov_a, rdy_a, busy_a, st_a, dout_a}, {1'b0, 1'b1, 1'b0, 2'b00, 16'h0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("aborted_quiet", {ov_a, busy_a}, {1'b0, 1'b0});
        end
        run_block(0, 2'b01, 32'h0000_4321, 64'h9876_5432, 0, res, st, lat);
        check("post_reset_enc", {st, res}, {2'b01, 16'd0, enc16(16'h4321, 32'h9876_5432)});

        // randomized ops on the 16-bit instance
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(1, 3));
            x  = {16'd0, 16'($urandom)};
            k  = {32'd0, $urandom};
            run_block(0, op, x, k, $urandom_range(0, 2), res, st, lat);
            if (op == 2'b01) e = enc16(x[15:0], k[31:0]);
            else if (op == 2'b10) e = dec16(x[15:0], k[31:0]);
            else e = 16'h0;
            check("rand_a", {st, res}, {op, 16'd0, e});
            check("rand_a_lat", lat, (op == 2'b11) ? 1 : 3);
        end

        // back-to-back requests with in_valid held high
        or_a = 1'b1;
        dcur = {16'd0, 16'($urandom)};
        kcur = {32'd0, $urandom};
        drive(0, 1'b1, 2'b01, dcur, kcur);
        prev_rdy = rdy_a;
        last_acc = -1;
        n_acc = 0;
        for (int c = 0; c < 44; c++) begin
            @(posedge clk); #1;
            if (prev_rdy) begin
                if (last_acc >= 0) check("b2b_spacing", c - last_acc, 4);
                last_acc = c;
                n_acc++;
                q.push_back(enc16(dcur[15:0], kcur[31:0]));
                dcur = {16'd0, 16'($urandom)};
                kcur = {32'd0, $urandom};
                drive(0, 1'b1, 2'b01, dcur, kcur);
            end
            if (ov_a) begin
                check("b2b_pending", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("b2b_data", {st_a, dout_a}, {2'b01, e});
                end
            end
            prev_rdy = rdy_a;
        end
        drive(0, 1'b0, 2'b00, 32'd0, 64'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ov_a && q.size() > 0) begin
                e = q.pop_front();
                check("b2b_data", {st_a, dout_a}, {2'b01, e});
            end
        end
        check("b2b_drained", q.size(), 0);
        check("b2b_count", n_acc >= 10, 1'b1);
        or_a = 1'b0;

        // 32-bit, 8-round instance: round trips with random keys
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            k = {$urandom, $urandom};
            run_block(1, 2'b01, x, k, 0, res, st, lat);
            check("b_enc", {st, res}, {2'b01, enc32(x, k)});
            check("b_enc_lat", lat, 8);
            run_block(1, 2'b10, res, k, 0, r2, st, lat);
            check("b_roundtrip", {st, r2}, {2'b10, x});
            check("b_dec_lat", lat, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
